fft8_controller: RTL and testbench

Sequencer for the 8-point radix-2 DIT FFT datapath. It accepts eight input samples over a valid/ready handshake and writes them to the working memory in bit-reversed order. It then issues the 12 butterflies of the three stages with their twiddle indices and write-back strobes, and finally streams the eight results out in natural order. It sits between the sample source/sink and the butterfly unit plus its 8-entry working memory, and replaces the free-running control inside the FFT processor top.

---
 rtl/fft8_pkg.sv | 29 ++
 rtl/fft8_addr_gen.sv | 26 ++
 rtl/fft8_controller.sv | 164 ++++++++++++++++
 tb/tb_fft8_controller.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft8_pkg.sv
// Shared types and helpers for the 8-point radix-2 DIT FFT sequencer.
package fft8_pkg;

  localparam int N     = 8;
  localparam int LOG2N = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_DRAIN,
    ST_OUTPUT
  } fft8_state_e;

  // Twiddle index m selects W8^m; only m = 0..3 occur in a DIT 8-point transform.
  typedef logic [1:0] tw_idx_t;

  // One slot of the write-back delay line.
  typedef struct packed {
    logic             valid;
    logic [LOG2N-1:0] a;
    logic [LOG2N-1:0] b;
  } wb_entry_t;

  function automatic logic [LOG2N-1:0] bitrev3(input logic [LOG2N-1:0] v);
    return {v[0], v[1], v[2]};
  endfunction

endpackage

// File: rtl/fft8_addr_gen.sv
// Combinational butterfly address/twiddle generator: (stage, k) -> (a, b, tw).
module fft8_addr_gen
  import fft8_pkg::*;
(
  input  logic [1:0]       stage,
  input  logic [1:0]       k,
  output logic [LOG2N-1:0] addr_a,
  output logic [LOG2N-1:0] addr_b,
  output tw_idx_t          tw
);

  logic [LOG2N-1:0] span;
  logic [LOG2N-1:0] j;
  logic [LOG2N-1:0] grp_base;

  // Butterflies in a stage are grouped in blocks of 2*span; j is the offset inside a block.
  always_comb begin
    span     = 3'd1 << stage;
    j        = {1'b0, k} & (span - 3'd1);
    grp_base = ({1'b0, k} >> stage) << ({1'b0, stage} + 3'd1);
    addr_a   = grp_base + j;
    addr_b   = addr_a + span;
    tw       = tw_idx_t'(j << (2'd2 - stage));
  end

endmodule

// File: rtl/fft8_controller.sv
// Sequencer for the 8-point DIT FFT: bit-reversed load, 3 stages of 4 butterflies, natural-order unload.
module fft8_controller
  import fft8_pkg::*;
#(
  parameter int BF_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ld_we,
  output logic [LOG2N-1:0] ld_addr,
  output logic             bf_valid,
  output logic [LOG2N-1:0] bf_addr_a,
  output logic [LOG2N-1:0] bf_addr_b,
  output tw_idx_t          bf_tw,
  output logic [1:0]       bf_stage,
  output logic             wb_en,
  output logic [LOG2N-1:0] wb_addr_a,
  output logic [LOG2N-1:0] wb_addr_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [LOG2N-1:0] out_addr,
  output logic             busy,
  output logic             done
);

  // Handshakes: a transfer happens in exactly the cycles where valid and ready
  // are both high; ready never depends on valid, and the controller holds its
  // own valid/address steady until the transfer completes.

  localparam logic [2:0]       DRAIN_LAST = 3'(BF_LAT - 1);
  localparam logic [1:0]       LAST_STAGE = 2'(LOG2N - 1);
  localparam logic [1:0]       LAST_K     = 2'(N / 2 - 1);
  localparam logic [LOG2N-1:0] LAST_IDX   = 3'(N - 1);

  fft8_state_e      state;
  fft8_state_e      state_nx;
  logic [LOG2N-1:0] n_q;
  logic [LOG2N-1:0] out_cnt_q;
  logic [1:0]       stage_q;
  logic [1:0]       k_q;
  logic [2:0]       drain_q;
  logic             done_q;
  logic             out_fire;
  logic [LOG2N-1:0] ag_a;
  logic [LOG2N-1:0] ag_b;
  tw_idx_t          ag_tw;
  wb_entry_t        line_q [BF_LAT];

  fft8_addr_gen u_addr_gen (
    .stage  (stage_q),
    .k      (k_q),
    .addr_a (ag_a),
    .addr_b (ag_b),
    .tw     (ag_tw)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    bf_valid  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nx = ST_LOAD;
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && n_q == LAST_IDX) state_nx = ST_ISSUE;
      end
      ST_ISSUE: begin
        bf_valid = 1'b1;
        if (k_q == LAST_K) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_q == DRAIN_LAST)
          state_nx = (stage_q == LAST_STAGE) ? ST_OUTPUT : ST_ISSUE;
      end
      ST_OUTPUT: begin
        out_valid = 1'b1;
        if (out_ready && out_cnt_q == LAST_IDX) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign ld_we     = in_valid & in_ready;
  assign ld_addr   = in_ready ? bitrev3(n_q) : '0;
  assign bf_addr_a = bf_valid ? ag_a : '0;
  assign bf_addr_b = bf_valid ? ag_b : '0;
  assign bf_tw     = bf_valid ? ag_tw : '0;
  assign bf_stage  = bf_valid ? stage_q : '0;
  assign out_fire  = out_valid & out_ready;
  assign out_addr  = out_valid ? out_cnt_q : '0;
  assign busy      = (state != ST_IDLE);
  assign done      = done_q;

  // Counters wrap naturally (n, k, out count) at the end of their phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q       <= '0;
      out_cnt_q <= '0;
      stage_q   <= '0;
      k_q       <= '0;
      drain_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= out_fire && (out_cnt_q == LAST_IDX);
      case (state)
        ST_IDLE: begin
          if (start) begin
            n_q       <= '0;
            out_cnt_q <= '0;
            stage_q   <= '0;
            k_q       <= '0;
            drain_q   <= '0;
          end
        end
        ST_LOAD: begin
          if (ld_we) n_q <= n_q + 3'd1;
        end
        ST_ISSUE: begin
          k_q     <= k_q + 2'd1;
          drain_q <= '0;
        end
        ST_DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            drain_q <= '0;
            if (stage_q != LAST_STAGE) stage_q <= stage_q + 2'd1;
          end else begin
            drain_q <= drain_q + 3'd1;
          end
        end
        ST_OUTPUT: begin
          if (out_fire) out_cnt_q <= out_cnt_q + 3'd1;
        end
        default: ;
      endcase
    end
  end

  // Write-back delay line runs regardless of state so the last issues of a
  // stage still retire during DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BF_LAT; i++) line_q[i] <= '0;
    end else begin
      line_q[0] <= '{valid: bf_valid, a: bf_addr_a, b: bf_addr_b};
      for (int i = 1; i < BF_LAT; i++) line_q[i] <= line_q[i-1];
    end
  end

  assign wb_en     = line_q[BF_LAT-1].valid;
  assign wb_addr_a = line_q[BF_LAT-1].a;
  assign wb_addr_b = line_q[BF_LAT-1].b;

endmodule

// File: tb/tb_fft8_controller.sv
// Bench for fft8_controller: cycle model of the transform schedule plus a BF_LAT sweep.
module tb_fft8_controller;

  localparam int LAT  = 2;
  localparam int SPAN = 4 + LAT;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, in_valid, out_ready;
  logic start_s, in_valid_s, out_ready_s;

  logic       in_ready, ld_we, bf_valid, wb_en, out_valid, busy, done;
  logic [2:0] ld_addr, bf_addr_a, bf_addr_b, wb_addr_a, wb_addr_b, out_addr;
  logic [1:0] bf_tw, bf_stage;

  fft8_controller #(.BF_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .in_ready(in_ready), .ld_we(ld_we), .ld_addr(ld_addr),
    .bf_valid(bf_valid), .bf_addr_a(bf_addr_a), .bf_addr_b(bf_addr_b),
    .bf_tw(bf_tw), .bf_stage(bf_stage),
    .wb_en(wb_en), .wb_addr_a(wb_addr_a), .wb_addr_b(wb_addr_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .busy(busy), .done(done)
  );

  typedef struct {int due; int a; int b; int st;} pend_t;

  // ---------------- BF_LAT sweep instances (measurement only) ----------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_sw
    localparam int LS = (gi == 0) ? 1 : 5;
    logic       s_in_ready, s_ld_we, s_bf_valid, s_wb_en, s_out_valid, s_busy, s_done;
    logic [2:0] s_ld_addr, s_a, s_b, s_wa, s_wb, s_out_addr;
    logic [1:0] s_tw, s_stage;
    int busy_len, span_len, wb_cnt, order_err, overlap_err, pend_n, ncyc;
    bit meas;
    pend_t q[$];
    pend_t e;

    fft8_controller #(.BF_LAT(LS)) dut_s (
      .clk(clk), .rst(rst), .start(start_s), .in_valid(in_valid_s),
      .in_ready(s_in_ready), .ld_we(s_ld_we), .ld_addr(s_ld_addr),
      .bf_valid(s_bf_valid), .bf_addr_a(s_a), .bf_addr_b(s_b),
      .bf_tw(s_tw), .bf_stage(s_stage),
      .wb_en(s_wb_en), .wb_addr_a(s_wa), .wb_addr_b(s_wb),
      .out_valid(s_out_valid), .out_ready(out_ready_s), .out_addr(s_out_addr),
      .busy(s_busy), .done(s_done)
    );

    initial begin
      busy_len = 0; span_len = 0; wb_cnt = 0; order_err = 0;
      overlap_err = 0; pend_n = 0; ncyc = 0; meas = 0;
      forever begin
        @(negedge clk);
        if (s_busy) busy_len++;
        if (meas) begin
          span_len++;
          if (s_done) meas = 0;
        end else if (start_s && !s_busy && span_len == 0) begin
          meas = 1;
          span_len = 1;
        end
        if (s_bf_valid)
          foreach (q[i]) if (q[i].st < int'(s_stage)) overlap_err++;
        if (s_wb_en) begin
          wb_cnt++;
          if (q.size() == 0) order_err++;
          else begin
            e = q.pop_front();
            if (e.due != ncyc || e.a != int'(s_wa) || e.b != int'(s_wb)) order_err++;
          end
        end
        if (s_bf_valid) q.push_back('{ncyc + LS, int'(s_a), int'(s_b), int'(s_stage)});
        pend_n = q.size();
        ncyc++;
      end
    end
  end

  // ---------------- scoreboard state ----------------
  int vectors = 0;
  int miscompares = 0;
  int timeouts = 0;
  bit final_req = 0;
  bit final_ack = 0;

  int ld_lit [8]  = '{0, 4, 2, 6, 1, 5, 3, 7};
  int iss_a  [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
  int iss_b  [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
  int iss_tw [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

  // Model: mode 0 idle, 1 load, 2 compute (cycle m_c of 3*SPAN), 3 output.
  int mode, m_n, m_c, m_oc, cyc, run_len, done_cnt, ph, idx;
  bit m_done, iss, e_wb;
  pend_t wbq[$];
  int runs[$];

  function automatic int brev(input int v);
    return ((v & 1) << 2) | (v & 2) | ((v >> 2) & 1);
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    end
  endtask

  // ---------------- model update + compare process ----------------
  initial begin
    mode = 0; m_n = 0; m_c = 0; m_oc = 0; cyc = 0; run_len = 0; done_cnt = 0; m_done = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        mode = 0; m_n = 0; m_c = 0; m_oc = 0; m_done = 0;
        wbq.delete();
      end else begin
        m_done = 0;
        if (wbq.size() > 0 && wbq[0].due == cyc) void'(wbq.pop_front());
        if (mode == 2 && (m_c % SPAN) < 4) begin
          idx = (m_c / SPAN) * 4 + (m_c % SPAN);
          wbq.push_back('{cyc + LAT, iss_a[idx], iss_b[idx], m_c / SPAN});
        end
        case (mode)
          0: if (start) begin mode = 1; m_n = 0; end
          1: if (in_valid) begin
               m_n++;
               if (m_n == 8) begin mode = 2; m_c = 0; end
             end
          2: begin
               m_c++;
               if (m_c == 3 * SPAN) begin mode = 3; m_oc = 0; end
             end
          default: if (out_ready) begin
               if (m_oc == 7) begin mode = 0; m_done = 1; end
               else m_oc++;
             end
        endcase
      end
      cyc++;

      @(negedge clk);
      ph  = m_c % SPAN;
      iss = (mode == 2) && (ph < 4);
      idx = iss ? (m_c / SPAN) * 4 + ph : 0;
      e_wb = (wbq.size() > 0) && (wbq[0].due == cyc);
      check("busy", busy, mode != 0);
      check("done", done, m_done);
      check("in_ready", in_ready, mode == 1);
      check("ld_we", ld_we, (mode == 1) && in_valid);
      check("ld_addr", ld_addr, (mode == 1) ? brev(m_n) : 0);
      if (mode == 1 && in_valid) check("ld_addr_literal", ld_addr, ld_lit[m_n]);
      check("bf_valid", bf_valid, iss);
      check("bf_addr_a", bf_addr_a, iss ? iss_a[idx] : 0);
      check("bf_addr_b", bf_addr_b, iss ? iss_b[idx] : 0);
      check("bf_tw", bf_tw, iss ? iss_tw[idx] : 0);
      check("bf_stage", bf_stage, iss ? m_c / SPAN : 0);
      check("wb_en", wb_en, e_wb);
      check("wb_addr_a", wb_addr_a, e_wb ? wbq[0].a : 0);
      check("wb_addr_b", wb_addr_b, e_wb ? wbq[0].b : 0);
      check("out_valid", out_valid, mode == 3);
      check("out_addr", out_addr, (mode == 3) ? m_oc : 0);

      if (done) done_cnt++;
      if (busy) run_len++;
      else if (run_len > 0) begin runs.push_back(run_len); run_len = 0; end

      if (final_req && !final_ack) begin
        check("wait_timeouts", timeouts, 0);
        check("first_run_busy_cycles", (runs.size() > 0) ? runs[0] : -1, 34);
        check("done_pulses", done_cnt, 5);
        check("lat1_busy_cycles", g_sw[0].busy_len, 31);
        check("lat1_start_to_done", g_sw[0].span_len, 33);
        check("lat1_wb_count", g_sw[0].wb_cnt, 12);
        check("lat1_wb_order", g_sw[0].order_err + g_sw[0].pend_n, 0);
        check("lat1_wb_overlap", g_sw[0].overlap_err, 0);
        check("lat5_busy_cycles", g_sw[1].busy_len, 43);
        check("lat5_start_to_done", g_sw[1].span_len, 45);
        check("lat5_wb_count", g_sw[1].wb_cnt, 12);
        check("lat5_wb_order", g_sw[1].order_err + g_sw[1].pend_n, 0);
        check("lat5_wb_overlap", g_sw[1].overlap_err, 0);
        final_ack = 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if (done) return;
      tick();
    end
    timeouts++;
  endtask

  task automatic run_clean();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    pulse_start();
    wait_done(100);
    in_valid = 1'b0;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    start_s = 1'b0; in_valid_s = 1'b1; out_ready_s = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Clean transform, no backpressure.
    run_clean();
    repeat (2) tick();

    // Toggling in_valid during load, out_ready low 3 cycles at count 4.
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      in_valid = (i % 2 == 0);
      tick();
    end
    in_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid && out_addr == 3'd4) begin found = 1; break; end
      tick();
    end
    if (!found) timeouts++;
    out_ready = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1;
    wait_done(50);
    repeat (2) tick();

    // start during ISSUE is ignored; start coincident with done restarts.
    in_valid = 1'b1;
    pulse_start();
    found = 0;
    for (int i = 0; i < 50; i++) begin
      if (bf_valid) begin found = 1; break; end
      tick();
    end
    if (!found) timeouts++;
    pulse_start();
    wait_done(100);
    pulse_start();
    wait_done(100);
    in_valid = 1'b0;
    repeat (2) tick();

    // Reset at stage 1, k = 2, then a clean transform.
    in_valid = 1'b1;
    pulse_start();
    found = 0;
    for (int i = 0; i < 50; i++) begin
      if (bf_valid && bf_stage == 2'd1 && bf_addr_a == 3'd4) begin found = 1; break; end
      tick();
    end
    if (!found) timeouts++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (10) tick();
    run_clean();

    // BF_LAT sweep instances.
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    repeat (80) tick();

    final_req = 1'b1;
    for (int i = 0; i < 10 && !final_ack; i++) tick();
    if (!final_ack) begin
      $display("FAIL final_report: scoreboard did not acknowledge, got 0 expected 1");
      $fatal(1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
